// File: rtl/core_pkg.sv
// Shared NRC core types: datapath width, PC step and the instruction-buffer entry.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fifo_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer; flush beats push, pop on empty is ignored.
module ifu_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         push,
    input  core_pkg::fifo_entry_t        push_data,
    input  logic                         pop,
    input  logic                         flush,
    output core_pkg::fifo_entry_t        head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    import core_pkg::*;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fifo_entry_t    r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic           w_push;
    logic           w_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rptr];

    assign w_pop  = pop & ~empty;
    assign w_push = push & ~flush;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b)
        !(w_push && full && !w_pop));

endmodule

// File: rtl/ifu_pf.sv
// Prefetching instruction fetch unit: credit-limited request issue, in-order responses
// into a small buffer, redirect flushes the buffer and drops in-flight responses.
module ifu_pf #(
    parameter int unsigned     XLEN       = core_pkg::XLEN,
    parameter logic [XLEN-1:0] PC_RST_VEC = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    input  logic [XLEN-1:0] ifu_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);
    import core_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic            r_started;

    fifo_entry_t     w_push_entry;
    fifo_entry_t     w_head;
    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;
    logic [CW-1:0]   w_live;
    logic [CW:0]     w_used;
    logic            w_has_credit;
    logic            w_req_fire;
    logic            w_rsp_push;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_unused;

    // Buffer slots already spoken for: occupied entries plus responses that will land.
    assign w_live       = r_outstanding - r_discard;
    assign w_used       = (CW+1)'(w_count) + (CW+1)'(w_live);
    assign w_has_credit = (w_used < (CW+1)'(FIFO_DEPTH));

    assign ifu_req_valid = r_started & ~redirect & w_has_credit;
    assign ifu_req_addr  = r_started ? r_fetch_pc : '0;
    assign w_req_fire    = ifu_req_valid & ifu_req_ready;

    assign w_rsp_push    = ifu_rsp_valid & ~redirect & (r_discard == '0);
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_push_entry  = '{pc: r_rsp_pc, inst: ifu_rsp_data};

    assign inst_valid = ~w_empty;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign w_unused   = &{1'b0, redirect_pc[1:0], w_full};

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (w_rsp_push),
        .push_data (w_push_entry),
        .pop       (inst_ready),
        .flush     (redirect),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_fetch_pc    <= PC_RST_VEC;
            r_rsp_pc      <= PC_RST_VEC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_started     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (redirect) begin
                // No request can fire this cycle; everything still in flight is stale.
                r_fetch_pc    <= w_redirect_pc;
                r_rsp_pc      <= w_redirect_pc;
                r_outstanding <= r_outstanding - CW'(ifu_rsp_valid);
                r_discard     <= r_outstanding - CW'(ifu_rsp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
                end
                r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(ifu_rsp_valid);
                if (ifu_rsp_valid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_rsp_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
                end
            end
        end
    end

    a_discard_bound: assert property (@(posedge clk) disable iff (!rst_b)
        r_discard <= r_outstanding);
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_b)
        r_outstanding <= CW'(FIFO_DEPTH));

endmodule
